// File: rtl/unit_seq_pkg.sv
// Shared types and constants for the round-robin phase sequencer.
package unit_seq_pkg;
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  localparam int PHW      = 3;
  localparam int MAX_WAIT = 4;
  localparam int DEF_NREQ = 4;
  localparam int DEF_RW   = 32;

  // Wait requests above MAX_WAIT clamp rather than wrap.
  function automatic logic [PHW-1:0] sat_wait(input logic [2:0] wc);
    return (int'(wc) > MAX_WAIT) ? PHW'(MAX_WAIT) : PHW'(wc);
  endfunction
endpackage

// File: rtl/unit_seq_rr_arb.sv
// Combinational round-robin pick: search starts one past ptr and wraps.
module unit_seq_rr_arb #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         pick,
  output logic [$clog2(NREQ)-1:0] pick_idx,
  output logic                    vld
);
  localparam int IW = $clog2(NREQ);

  always_comb begin
    int k;
    k        = 0;
    pick     = '0;
    pick_idx = '0;
    vld      = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!vld && req[k]) begin
        vld      = 1'b1;
        pick[k]  = 1'b1;
        pick_idx = IW'(k);
      end
    end
  end
endmodule

// File: rtl/unit_seq_ctrl.sv
// Shares one engine among NREQ requesters and emits a/b/c/d/done/busy/r.
// Build option UNIT_SEQ_WAIT_EN enables the wait_cyc a->b stretch.
module unit_seq_ctrl import unit_seq_pkg::*; #(
  parameter int NREQ = DEF_NREQ,
  parameter int RW   = DEF_RW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      wait_cyc,
  output logic [NREQ-1:0] gnt,
  output logic            a,
  output logic            b,
  output logic            c,
  output logic            d,
  output logic            done,
  output logic            busy,
  output logic [RW-1:0]   r
);
  localparam int IW = $clog2(NREQ);

  state_t          state, state_n;
  logic [PHW-1:0]  ph, ph_n, w, w_n, wsel, len_m1;
  logic [NREQ-1:0] gnt_n, pick;
  logic [IW-1:0]   ptr, ptr_n, pick_idx;
  logic            pick_vld, arb_en, act_n;
  logic            a_n, b_n, c_n, d_n, done_n;

`ifdef UNIT_SEQ_WAIT_EN
  assign wsel = sat_wait(wait_cyc);
`else
  logic unused_wait;
  assign unused_wait = ^wait_cyc;
  assign wsel        = '0;
`endif

  unit_seq_rr_arb #(.NREQ(NREQ)) u_arb (
    .req      (req),
    .ptr      (ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .vld      (pick_vld)
  );

  assign len_m1 = w + PHW'(3);

  always_comb begin
    state_n = state;
    ph_n    = ph;
    w_n     = w;
    gnt_n   = gnt;
    ptr_n   = ptr;
    arb_en  = (state == IDLE) || (ph == len_m1);
    case (state)
      IDLE: ;
      ACTIVE: begin
        ph_n = ph + PHW'(1);
        if (ph == '0) w_n = wsel;
        if (ph == len_m1) begin
          state_n = IDLE;
          gnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    // A fresh grant overrides the fall to IDLE, giving back-to-back transactions.
    if (arb_en && pick_vld) begin
      state_n = ACTIVE;
      ph_n    = '0;
      gnt_n   = pick;
      ptr_n   = pick_idx;
    end
  end

  // Strobes are decoded from the next phase so every output leaves a flop.
  always_comb begin
    act_n  = (state_n == ACTIVE);
    a_n    = act_n && (ph_n == '0);
    c_n    = act_n && (ph_n != '0) && (ph_n <= w_n + PHW'(3));
    d_n    = act_n && (ph_n == PHW'(2));
    b_n    = act_n && (ph_n == w_n + PHW'(1));
    done_n = act_n && (ph_n == w_n + PHW'(3));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ph    <= '0;
      w     <= '0;
      ptr   <= IW'(NREQ - 1);
      gnt   <= '0;
      a     <= 1'b0;
      b     <= 1'b0;
      c     <= 1'b0;
      d     <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
      r     <= '0;
    end else begin
      state <= state_n;
      ph    <= ph_n;
      w     <= w_n;
      ptr   <= ptr_n;
      gnt   <= gnt_n;
      a     <= a_n;
      b     <= b_n;
      c     <= c_n;
      d     <= d_n;
      done  <= done_n;
      busy  <= act_n;
      r     <= a ? '0 : r + RW'(1);
    end
  end
endmodule

// File: tb/tb_unit_seq_ctrl.sv
// Randomized and directed bench for unit_seq_ctrl against a transaction-level model.
module tb_unit_seq_ctrl;
  localparam int TN  = 4;
  localparam int TRW = 4;
  localparam int VW  = TN + 6 + TRW;
`ifdef UNIT_SEQ_WAIT_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [TN-1:0]  req = '0;
  logic [2:0]     wait_cyc = '0;
  logic [TN-1:0]  gnt;
  logic           a, b, c, d, done, busy;
  logic [TRW-1:0] r;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: transaction offset since its start, its wait, owner and last owner.
  bit m_active = 1'b0;
  int m_off = 0, m_w = 0, m_gnt = 0, m_last = TN - 1, m_r = 0;

  always #5 clk = ~clk;

  unit_seq_ctrl #(.NREQ(TN), .RW(TRW)) dut (
    .clk(clk), .rst(rst), .req(req), .wait_cyc(wait_cyc),
    .gnt(gnt), .a(a), .b(b), .c(c), .d(d), .done(done), .busy(busy), .r(r)
  );

  function automatic int wsel(input int wc);
    return WEN ? ((wc > 4) ? 4 : wc) : 0;
  endfunction

  function automatic logic [VW-1:0] model_vec();
    logic [TN-1:0] g;
    logic ea, eb, ec, ed, edn;
    g   = m_active ? TN'(1 << m_gnt) : '0;
    ea  = m_active && m_off == 0;
    eb  = m_active && m_off == m_w + 1;
    ec  = m_active && m_off >= 1 && m_off <= m_w + 3;
    ed  = m_active && m_off == 2;
    edn = m_active && m_off == m_w + 3;
    return {g, ea, eb, ec, ed, edn, m_active, TRW'(m_r)};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {gnt, a, b, c, d, done, busy, r};
  endfunction

  task automatic model_update(input logic [TN-1:0] rq, input int wc, input bit rs);
    bit boundary, prev_a;
    int k;
    if (rs) begin
      m_active = 1'b0; m_off = 0; m_w = 0; m_last = TN - 1; m_r = 0;
      return;
    end
    prev_a   = m_active && m_off == 0;
    m_r      = prev_a ? 0 : (m_r + 1) % (1 << TRW);
    boundary = !m_active || m_off == m_w + 3;
    if (m_active) begin
      if (m_off == 0) m_w = wsel(wc);
      m_off++;
    end
    if (boundary) begin
      m_active = 1'b0;
      for (int i = 1; i <= TN; i++) begin
        k = (m_last + i) % TN;
        if (!m_active && rq[k]) begin
          m_active = 1'b1; m_off = 0; m_gnt = k; m_last = k;
        end
      end
    end
  endtask

  task automatic step(input logic [TN-1:0] rq, input logic [2:0] wc, input bit rs);
    req = rq; wait_cyc = wc; rst = rs;
    @(posedge clk);
    model_update(rq, int'(wc), rs);
    #1;
  endtask

  task automatic test_reset();
    step('0, 3'd0, 1'b1);
    step('0, 3'd0, 1'b1);
    n_cmp++;
    if (obs_vec() !== '0) begin
      n_bad++; $display("FAIL reset_state: got %h want %h", obs_vec(), {VW{1'b0}});
    end
  endtask

  task automatic test_single();
    int since_a;
    since_a = -1;
    step('0, 3'd0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step(4'b0001, 3'd0, 1'b0);
      n_cmp++;
      if (obs_vec() !== model_vec()) begin
        n_bad++; $display("FAIL single_cyc%0d: got %h want %h", i, obs_vec(), model_vec());
      end
      if (a) since_a = 0; else if (since_a >= 0) since_a++;
      if (since_a == 1) begin
        n_cmp++;
        if (r !== '0 || gnt !== 4'b0001) begin
          n_bad++; $display("FAIL single_ph1: got r=%0d gnt=%b want r=0 gnt=0001", r, gnt);
        end
      end
      if (since_a == 3) begin
        n_cmp++;
        if (done !== 1'b1) begin
          n_bad++; $display("FAIL single_done_ph3: got %b want 1", done);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [TN-1:0] seen[$];
    logic [TN-1:0] order[5];
    int last_a, gap_bad;
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    last_a = -1; gap_bad = 0;
    step('0, 3'd0, 1'b1);
    for (int i = 0; i < 22; i++) begin
      step(4'b1111, 3'd0, 1'b0);
      n_cmp++;
      if (obs_vec() !== model_vec()) begin
        n_bad++; $display("FAIL rr_cyc%0d: got %h want %h", i, obs_vec(), model_vec());
      end
      if (a) begin
        seen.push_back(gnt);
        if (last_a >= 0 && i - last_a != 4) gap_bad++;
        last_a = i;
      end
    end
    n_cmp++;
    if (seen.size() < 5 || gap_bad != 0) begin
      n_bad++; $display("FAIL rr_count: got %0d grants %0d bad gaps want >=5 and 0", seen.size(), gap_bad);
    end else begin
      for (int j = 0; j < 5; j++) begin
        n_cmp++;
        if (seen[j] !== order[j]) begin
          n_bad++; $display("FAIL rr_order%0d: got %b want %b", j, seen[j], order[j]);
        end
      end
    end
  endtask

  task automatic test_wait(input logic [2:0] wc);
    int since_a, b_off, dn_off, exp_w;
    since_a = -1; b_off = -1; dn_off = -1;
    exp_w = WEN ? ((int'(wc) > 4) ? 4 : int'(wc)) : 0;
    step('0, 3'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(4'b0001, wc, 1'b0);
      n_cmp++;
      if (obs_vec() !== model_vec()) begin
        n_bad++; $display("FAIL wait%0d_cyc%0d: got %h want %h", wc, i, obs_vec(), model_vec());
      end
      if (a && since_a < 0) since_a = 0; else if (since_a >= 0) since_a++;
      if (b && b_off < 0) b_off = since_a;
      if (done && dn_off < 0) dn_off = since_a;
    end
    n_cmp++;
    if (b_off != exp_w + 1 || dn_off != exp_w + 3) begin
      n_bad++; $display("FAIL wait%0d_shape: got b@%0d done@%0d want b@%0d done@%0d",
                        wc, b_off, dn_off, exp_w + 1, exp_w + 3);
    end
  endtask

  task automatic test_mid_events();
    int n_done;
    n_done = 0;
    step('0, 3'd0, 1'b1);
    step(4'b0001, 3'd0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step('0, 3'd0, 1'b0);
      if (done) n_done++;
      n_cmp++;
      if (obs_vec() !== model_vec()) begin
        n_bad++; $display("FAIL drop_cyc%0d: got %h want %h", i, obs_vec(), model_vec());
      end
    end
    n_cmp++;
    if (n_done != 1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL drop_complete: got done=%0d busy=%b want 1 0", n_done, busy);
    end
    step(4'b0010, 3'd0, 1'b0);
    step(4'b0010, 3'd0, 1'b0);
    step(4'b0010, 3'd0, 1'b0);
    step(4'b0010, 3'd0, 1'b1);
    n_cmp++;
    if (obs_vec() !== '0) begin
      n_bad++; $display("FAIL rst_mid: got %h want %h", obs_vec(), {VW{1'b0}});
    end
    step(4'b1111, 3'd0, 1'b0);
    n_cmp++;
    if (gnt !== 4'b0001 || a !== 1'b1 || obs_vec() !== model_vec()) begin
      n_bad++; $display("FAIL rst_first_gnt: got %h want gnt=0001 a=1 (%h)", obs_vec(), model_vec());
    end
  endtask

  task automatic test_r_wrap();
    step('0, 3'd0, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      step('0, 3'd0, 1'b0);
      n_cmp++;
      if (r !== TRW'(i % 16) || obs_vec() !== model_vec()) begin
        n_bad++; $display("FAIL rwrap_%0d: got r=%0d want %0d", i, r, i % 16);
      end
    end
    step(4'b0001, 3'd0, 1'b0);
    step('0, 3'd0, 1'b0);
    n_cmp++;
    if (r !== '0) begin
      n_bad++; $display("FAIL rwrap_after_a: got %0d want 0", r);
    end
  endtask

  task automatic test_random();
    logic [TN-1:0] rq;
    logic [2:0] wc;
    bit rs;
    step('0, 3'd0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      rq = TN'($urandom);
      if ($urandom_range(0, 3) == 0) rq = '0;
      wc = 3'($urandom_range(0, 7));
      rs = ($urandom_range(0, 59) == 0);
      step(rq, wc, rs);
      n_cmp++;
      if (obs_vec() !== model_vec()) begin
        n_bad++; $display("FAIL random_cyc%0d: got %h want %h", i, obs_vec(), model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wait(3'd0);
    test_wait(3'd3);
    test_wait(3'd4);
    test_wait(3'd7);
    test_mid_events();
    test_r_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
